lcd_addr_seq: RTL and testbench

LCD_ADDR_SEQ -- requirements
Module: lcd_addr_seq

---
 rtl/lcd_pkg.sv | 14 +
 rtl/lcd_axis_cnt.sv | 31 +++
 rtl/lcd_addr_seq.sv | 154 +++++++++++++++
 tb/tb_lcd_addr_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD window address sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lcd_pkg;

    localparam int ADDR_WIDTH_DEF = 17;
    localparam int DIM_WIDTH_DEF  = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/lcd_axis_cnt.sv
// Single-axis pixel/line counter: counts 0..last, wraps to 0, flags terminal count.
// Latency: count updates one cycle after inc; tc is combinational on the count.
// Backpressure: advances only when inc is high; clr holds it at zero.
module lcd_axis_cnt
    import lcd_pkg::*;
#(
    parameter int WIDTH = DIM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == last);

    // Count up on inc, wrap to zero after the terminal value, clear dominates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/lcd_addr_seq.sv
// Rectangular-window frame-buffer read address generator with optional looping.
// Latency: first address the cycle after start; one address per accepted transfer, no bubbles.
// Backpressure: addr/line_last/frame_last hold while addr_ready is low.
module lcd_addr_seq
    import lcd_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  line_last,
    output logic                  frame_last,
    output logic                  busy,
    output logic                  frame_done
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DIM_WIDTH-1:0]  width_q;
    logic [DIM_WIDTH-1:0]  height_q;
    logic [DIM_WIDTH-1:0]  x_last;
    logic [DIM_WIDTH-1:0]  y_last;
    logic [DIM_WIDTH-1:0]  x_cnt;
    logic [DIM_WIDTH-1:0]  y_cnt;
    logic                  x_tc;
    logic                  y_tc;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  xfer;
    logic                  cnt_clr;
    logic                  start_ok;
    logic                  dims_ok;

    assign xfer     = valid_q & addr_ready;
    assign cnt_clr  = (state == ST_IDLE);
    assign x_last   = width_q - DIM_WIDTH'(1);
    assign y_last   = height_q - DIM_WIDTH'(1);
    assign start_ok = start & ~abort;
    assign dims_ok  = (width != '0) && (height != '0);

    // Counters sit at zero in IDLE so every accepted start begins at the top-left pixel.
    lcd_axis_cnt #(.WIDTH(DIM_WIDTH)) u_x_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .inc  (xfer),
        .last (x_last),
        .cnt  (x_cnt),
        .tc   (x_tc)
    );

    lcd_axis_cnt #(.WIDTH(DIM_WIDTH)) u_y_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .inc  (xfer & x_tc),
        .last (y_last),
        .cnt  (y_cnt),
        .tc   (y_tc)
    );

    // Flags derive from the counter registers; gating with valid keeps them low in IDLE.
    assign line_last  = valid_q & x_tc;
    assign frame_last = valid_q & x_tc & y_tc;

    assign addr       = addr_q;
    assign addr_valid = valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Control FSM plus address generation; abort is applied last so it overrides loop reload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            stride_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
            line_base <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        if (dims_ok) begin
                            base_q    <= base;
                            stride_q  <= stride;
                            width_q   <= width;
                            height_q  <= height;
                            line_base <= base;
                            addr_q    <= base;
                            valid_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            state     <= ST_RUN;
                        end else begin
                            // Empty window: report completion without emitting addresses.
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (frame_last) begin
                            done_q <= 1'b1;
                            if (loop_en) begin
                                line_base <= base_q;
                                addr_q    <= base_q;
                            end else begin
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                state   <= ST_IDLE;
                            end
                        end else if (line_last) begin
                            line_base <= line_base + stride_q;
                            addr_q    <= line_base + stride_q;
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                        end
                    end
                    if (abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_addr_seq.sv
// Scoreboard bench for lcd_addr_seq: expected addresses queued at start, checked per transfer.
// Latency: checks frame_done one cycle after the final transfer of each frame.
// Backpressure: exercises ready stalls and verifies address hold.
module tb_lcd_addr_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic        loop_en;
    logic [16:0] base;
    logic [8:0]  width;
    logic [8:0]  height;
    logic [16:0] stride;
    logic [16:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        line_last;
    logic        frame_last;
    logic        busy;
    logic        frame_done;

    typedef struct {
        logic [16:0] a;
        logic        ll;
        logic        fl;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        fd_exp = 1'b0;
    logic        hold_pend = 1'b0;
    logic [16:0] hold_addr = '0;

    lcd_addr_seq #(.ADDR_WIDTH(17), .DIM_WIDTH(9)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .loop_en    (loop_en),
        .base       (base),
        .width      (width),
        .height     (height),
        .stride     (stride),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .line_last  (line_last),
        .frame_last (frame_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference window walk: line starts step by stride, 17-bit wrap.
    task automatic push_frame(input logic [16:0] b, input int w, input int h, input logic [16:0] s);
        logic [16:0] lb;
        exp_t        e;
        lb = b;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.a  = lb + 17'(x);
                e.ll = (x == w - 1);
                e.fl = (x == w - 1) && (y == h - 1);
                sb.push_back(e);
            end
            lb = lb + s;
        end
    endtask

    // One cycle, entered and left at a falling edge where outputs are stable.
    task automatic step(input logic rdy, input logic ab, input logic lp, input logic st);
        logic xf;
        logic fd_next;
        exp_t e;
        chk("frame_done", frame_done, fd_exp);
        chk("busy", busy, sb.size() != 0);
        chk("addr_valid", addr_valid, sb.size() != 0);
        if (hold_pend) chk("addr_hold", addr, hold_addr);
        addr_ready = rdy;
        abort      = ab;
        loop_en    = lp;
        start      = st;
        xf         = addr_valid && rdy;
        fd_next    = 1'b0;
        if (xf) begin
            if (sb.size() == 0) begin
                chk("extra_xfer", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("addr", addr, e.a);
                chk("line_last", line_last, e.ll);
                chk("frame_last", frame_last, e.fl);
                fd_next = e.fl;
            end
        end
        if (ab) sb.delete();
        if (st && !ab && sb.size() == 0 && (width == 0 || height == 0)) fd_next = 1'b1;
        hold_pend = addr_valid && !rdy;
        hold_addr = addr;
        fd_exp    = fd_next;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [16:0] b, input logic [8:0] w, input logic [8:0] h,
                            input logic [16:0] s);
        base   = b;
        width  = w;
        height = h;
        stride = s;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        if (w != 0 && h != 0) push_frame(b, int'(w), int'(h), s);
        // Scramble configuration: it must not affect the scan in progress.
        base   = 17'($urandom);
        width  = 9'($urandom_range(1, 511));
        height = 9'($urandom_range(1, 511));
        stride = 17'($urandom);
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 repeating. Loop kept on while sb > keep.
    task automatic scan(input int mode, input int keep, input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            step((mode == 0) ? 1'b1 : (c % 3 == 0), 1'b0, sb.size() > keep, 1'b0);
            c++;
        end
        if (sb.size() != 0) begin
            chk("scan_timeout", 1, 0);
            sb.delete();
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        loop_en    = 1'b0;
        addr_ready = 1'b0;
        base       = '0;
        width      = '0;
        height     = '0;
        stride     = '0;
        @(negedge clk);
        chk("rst_addr", addr, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_line_last", line_last, 0);
        chk("rst_frame_last", frame_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic scan
        do_start(17'd100, 9'd4, 9'd2, 17'd320);
        scan(0, 100000, 50);

        // Backpressure with ready 1,0,0
        do_start(17'd100, 9'd4, 9'd2, 17'd320);
        scan(1, 100000, 60);

        // Loop: three frames, loop_en dropped for the last frame end
        do_start(17'd0, 9'd2, 9'd2, 17'd8);
        push_frame(17'd0, 2, 2, 17'd8);
        push_frame(17'd0, 2, 2, 17'd8);
        scan(0, 4, 50);

        // Abort after third transfer, then rescan
        do_start(17'd100, 9'd4, 9'd2, 17'd320);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        do_start(17'd100, 9'd4, 9'd2, 17'd320);
        scan(0, 100000, 50);

        // Zero size: height 0, then width 0
        do_start(17'd5, 9'd3, 9'd0, 17'd10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        do_start(17'd5, 9'd0, 9'd3, 17'd10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Abort beats start in IDLE
        base   = 17'd7;
        width  = 9'd2;
        height = 9'd2;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Address wrap
        do_start(17'h1FFFE, 9'd3, 9'd1, 17'd0);
        scan(0, 100000, 20);

        // 1x1 window: abort together with the frame_last transfer, loop_en ignored
        do_start(17'd55, 9'd1, 9'd1, 17'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-scan discards the scan
        do_start(17'd100, 9'd4, 9'd2, 17'd320);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", addr_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", addr, 0);
        chk("arst_line_last", line_last, 0);
        sb.delete();
        fd_exp    = 1'b0;
        hold_pend = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        do_start(17'd100, 9'd4, 9'd2, 17'd320);
        scan(0, 100000, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
